// File: rtl/arbiter_pkg.sv
// Shared constants and state encoding for the burst grant controller.
// The optional stall-timeout constant is consumed only when ARB_STALL_TIMEOUT_EN is defined.
package arbiter_pkg;

    localparam int WIDTH   = 4;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int IDX_W   = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        GRANT
    } burst_state_t;

endpackage

// File: rtl/burst_grant_ctrl_if.sv
// Arbiter-side request/grant signals and resource-side beat handshake of the burst controller.
// The controller uses the slave modport; whatever drives requests and accepts beats uses master.
interface burst_grant_ctrl_if;

    logic [arbiter_pkg::WIDTH-1:0]                    req_i;
    logic [arbiter_pkg::WIDTH-1:0]                    gnt_comb_i;
    logic [arbiter_pkg::WIDTH*arbiter_pkg::LEN_W-1:0] len_i;
    logic                                             beat_ready_i;
    logic [arbiter_pkg::WIDTH-1:0]                    gnt_o;
    logic [arbiter_pkg::IDX_W-1:0]                    id_o;
    logic                                             beat_valid_o;
    logic                                             last_o;
    logic                                             busy_o;
    logic                                             abort_o;

    modport slave (
        input  req_i, gnt_comb_i, len_i, beat_ready_i,
        output gnt_o, id_o, beat_valid_o, last_o, busy_o, abort_o
    );

    modport master (
        output req_i, gnt_comb_i, len_i, beat_ready_i,
        input  gnt_o, id_o, beat_valid_o, last_o, busy_o, abort_o
    );

endinterface

// File: rtl/onehot_to_idx.sv
// One-hot to binary encoder; if more than one bit is set, the lowest set bit wins.
module onehot_to_idx #(
    parameter int N = 4
) (
    input  logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx
);

    // Scanning from the top down lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                idx = ($clog2(N))'(i);
            end
        end
    end

endmodule

// File: rtl/burst_grant_ctrl.sv
// Locks the arbiter's grant for a per-requester burst and offers beats to the shared resource.
// Define ARB_STALL_TIMEOUT_EN to abort bursts that stall for TIMEOUT consecutive cycles.
module burst_grant_ctrl
    import arbiter_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    burst_grant_ctrl_if.slave  bus
);

    burst_state_t       state_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   gnt_q;
    logic [IDX_W-1:0]   id_q;
    logic               valid_q;
    logic               last_q;
    logic               busy_q;
    logic               abort_q;

    logic [WIDTH-1:0]   gnt_low;
    logic [IDX_W-1:0]   enc_idx;
    logic [LEN_W-1:0]   len_sel;
    logic               completing;
    logic               holder_drop;
    logic               timeout_hit;

    // An illegal multi-hot arbiter result is reduced to its lowest bit so gnt_o stays one-hot.
    assign gnt_low = bus.gnt_comb_i & (~bus.gnt_comb_i + WIDTH'(1));

    onehot_to_idx #(
        .N (WIDTH)
    ) u_enc (
        .onehot (bus.gnt_comb_i),
        .idx    (enc_idx)
    );

    assign len_sel     = bus.len_i[int'(enc_idx) * LEN_W +: LEN_W];
    assign completing  = bus.beat_ready_i && (cnt_q == '0);
    assign holder_drop = !bus.req_i[id_q];

`ifdef ARB_STALL_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_q;

    assign timeout_hit = (state_q == GRANT) && !bus.beat_ready_i
                         && (stall_q == STALL_W'(TIMEOUT - 1));

    // Held at zero while idle, so every new burst starts with a fresh stall budget.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (state_q != GRANT || bus.beat_ready_i) begin
            stall_q <= '0;
        end else if (stall_q != STALL_W'(TIMEOUT)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.gnt_comb_i != '0) begin
                        state_q <= GRANT;
                        gnt_q   <= gnt_low;
                        id_q    <= enc_idx;
                        cnt_q   <= len_sel;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        last_q  <= (len_sel == '0);
                    end
                end
                GRANT: begin
                    // Completion outranks a drop or timeout landing on the same edge.
                    if (completing || holder_drop || timeout_hit) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        gnt_q   <= '0;
                        id_q    <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        last_q  <= 1'b0;
                        abort_q <= !completing;
                    end else if (bus.beat_ready_i) begin
                        cnt_q  <= cnt_q - LEN_W'(1);
                        last_q <= (cnt_q == LEN_W'(1));
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_o        = gnt_q;
    assign bus.id_o         = id_q;
    assign bus.beat_valid_o = valid_q;
    assign bus.last_o       = last_q;
    assign bus.busy_o       = busy_q;
    assign bus.abort_o      = abort_q;

endmodule

// File: tb/tb_burst_grant_ctrl.sv
// Directed self-checking bench for burst_grant_ctrl; the timeout scenario follows ARB_STALL_TIMEOUT_EN.
module tb_burst_grant_ctrl;
    import arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    burst_grant_ctrl_if bus ();

    burst_grant_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] req, input logic [3:0] gnt_comb,
                                  input logic [15:0] len, input logic ready);
        bus.req_i        = req;
        bus.gnt_comb_i   = gnt_comb;
        bus.len_i        = len;
        bus.beat_ready_i = ready;
    endtask

    task automatic check_one(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic [3:0] gnt, input logic [1:0] id,
                                input logic valid, input logic last, input logic busy,
                                input logic abort);
        check_one({tag, ".gnt"},   32'(bus.gnt_o),        32'(gnt));
        check_one({tag, ".id"},    32'(bus.id_o),         32'(id));
        check_one({tag, ".valid"}, 32'(bus.beat_valid_o), 32'(valid));
        check_one({tag, ".last"},  32'(bus.last_o),       32'(last));
        check_one({tag, ".busy"},  32'(bus.busy_o),       32'(busy));
        check_one({tag, ".abort"}, 32'(bus.abort_o),      32'(abort));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        $display("[TB] starting burst_grant_ctrl directed sequence");

        // Reset held with an active arbiter grant: all outputs stay low.
        rst_n = 1'b0;
        apply_stimulus(4'b1111, 4'b0001, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("reset", 4'b0000, 2'd0, 0, 0, 0, 0);
        end
        rst_n = 1'b1;
        tick();
        check_output("first_grant", 4'b0001, 2'd0, 1, 1, 1, 0);
        apply_stimulus(4'b1111, 4'b0000, 16'h0000, 1'b1);
        tick();
        check_output("first_done", 4'b0000, 2'd0, 0, 0, 0, 0);

        // Basic burst on requester 1 with len=2, then requester 2 follows.
        apply_stimulus(4'b0110, 4'b0010, 16'h0020, 1'b1);
        tick();
        check_output("basic_c1", 4'b0010, 2'd1, 1, 0, 1, 0);
        apply_stimulus(4'b0110, 4'b0100, 16'h0020, 1'b1);
        tick();
        check_output("basic_c2", 4'b0010, 2'd1, 1, 0, 1, 0);
        tick();
        check_output("basic_c3", 4'b0010, 2'd1, 1, 1, 1, 0);
        tick();
        check_output("basic_c4", 4'b0000, 2'd0, 0, 0, 0, 0);
        tick();
        check_output("basic_c5", 4'b0100, 2'd2, 1, 1, 1, 0);
        apply_stimulus(4'b0110, 4'b0000, 16'h0020, 1'b1);
        tick();
        check_output("basic_end", 4'b0000, 2'd0, 0, 0, 0, 0);

        // Stalls: len=1, ready low, high, low, high across the four valid cycles.
        apply_stimulus(4'b0001, 4'b0001, 16'h0001, 1'b0);
        tick();
        check_output("stall_c1", 4'b0001, 2'd0, 1, 0, 1, 0);
        apply_stimulus(4'b0001, 4'b0000, 16'h0001, 1'b0);
        tick();
        check_output("stall_c2", 4'b0001, 2'd0, 1, 0, 1, 0);
        bus.beat_ready_i = 1'b1;
        tick();
        check_output("stall_c3", 4'b0001, 2'd0, 1, 1, 1, 0);
        bus.beat_ready_i = 1'b0;
        tick();
        check_output("stall_c4", 4'b0001, 2'd0, 1, 1, 1, 0);
        bus.beat_ready_i = 1'b1;
        tick();
        check_output("stall_end", 4'b0000, 2'd0, 0, 0, 0, 0);

        // Holder drop after two accepted beats of a six-beat burst.
        apply_stimulus(4'b0100, 4'b0100, 16'h0500, 1'b1);
        tick();
        check_output("drop_c1", 4'b0100, 2'd2, 1, 0, 1, 0);
        bus.gnt_comb_i = 4'b0000;
        tick();
        check_output("drop_c2", 4'b0100, 2'd2, 1, 0, 1, 0);
        tick();
        check_output("drop_c3", 4'b0100, 2'd2, 1, 0, 1, 0);
        bus.req_i = 4'b0000;
        tick();
        check_output("drop_abort", 4'b0000, 2'd0, 0, 0, 0, 1);
        tick();
        check_output("drop_after", 4'b0000, 2'd0, 0, 0, 0, 0);

        // Drop on the only beat completes normally.
        apply_stimulus(4'b1000, 4'b1000, 16'h0000, 1'b1);
        tick();
        check_output("lastdrop_c1", 4'b1000, 2'd3, 1, 1, 1, 0);
        apply_stimulus(4'b0000, 4'b0000, 16'h0000, 1'b1);
        tick();
        check_output("lastdrop_end", 4'b0000, 2'd0, 0, 0, 0, 0);
        tick();
        check_output("lastdrop_after", 4'b0000, 2'd0, 0, 0, 0, 0);

        // Multi-hot arbiter result: lowest bit wins.
        apply_stimulus(4'b0110, 4'b0110, 16'h0000, 1'b1);
        tick();
        check_output("multihot", 4'b0010, 2'd1, 1, 1, 1, 0);
        bus.gnt_comb_i = 4'b0000;
        tick();
        check_output("multihot_end", 4'b0000, 2'd0, 0, 0, 0, 0);

        // Maximum length: 16 beats, last only on the 16th.
        apply_stimulus(4'b0001, 4'b0001, 16'h000F, 1'b1);
        tick();
        check_output("maxlen_c1", 4'b0001, 2'd0, 1, 0, 1, 0);
        bus.gnt_comb_i = 4'b0000;
        for (int i = 2; i <= 16; i++) begin
            tick();
            check_output($sformatf("maxlen_c%0d", i), 4'b0001, 2'd0, 1, (i == 16), 1, 0);
        end
        tick();
        check_output("maxlen_end", 4'b0000, 2'd0, 0, 0, 0, 0);

        // Reset mid-burst clears everything.
        apply_stimulus(4'b0001, 4'b0001, 16'h000F, 1'b1);
        tick();
        check_output("midrst_grant", 4'b0001, 2'd0, 1, 0, 1, 0);
        bus.gnt_comb_i = 4'b0000;
        rst_n = 1'b0;
        tick();
        check_output("midrst_reset", 4'b0000, 2'd0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        check_output("midrst_idle", 4'b0000, 2'd0, 0, 0, 0, 0);

        // Indefinite stall: aborts after TIMEOUT stall cycles only in the timeout build.
        apply_stimulus(4'b0001, 4'b0001, 16'h0001, 1'b0);
        tick();
        check_output("tmo_c1", 4'b0001, 2'd0, 1, 0, 1, 0);
        bus.gnt_comb_i = 4'b0000;
`ifdef ARB_STALL_TIMEOUT_EN
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            check_output($sformatf("tmo_stall%0d", i), 4'b0001, 2'd0, 1, 0, 1, 0);
        end
        tick();
        check_output("tmo_abort", 4'b0000, 2'd0, 0, 0, 0, 1);
        tick();
        check_output("tmo_after", 4'b0000, 2'd0, 0, 0, 0, 0);
`else
        for (int i = 1; i <= 100; i++) begin
            tick();
            check_output($sformatf("hold_stall%0d", i), 4'b0001, 2'd0, 1, 0, 1, 0);
        end
        bus.beat_ready_i = 1'b1;
        tick();
        check_output("hold_last", 4'b0001, 2'd0, 1, 1, 1, 0);
        tick();
        check_output("hold_end", 4'b0000, 2'd0, 0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
